// File: rtl/seq_generator.sv
// seq_generator: serial pattern transmitter.
//
// Loads a pattern word and shifts its low `len` bits out MSB-first on `x`,
// repeating the frame `reps` times (reps=0 repeats until `stop`). Frames run
// back-to-back. After the last bit of a finite job there is one DONE cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       job request, sampled only in IDLE
//   stop        synchronous abort, honoured only in SHIFT
//   pattern     bits to send; bit len-1 goes first
//   len         frame length in bits, legal 1..WIDTH
//   reps        frame count, 0 = continuous
//   x           registered serial data (IDLE_BIT when valid=0)
//   valid       x carries pattern data this cycle
//   frame_start pulse with the first bit of every frame
//   busy        job in progress (SHIFT or DONE)
//   done        pulse in the cycle after the final bit of a completed job
//   err         pulse in the cycle after a start with an illegal len
//   dbg_state   current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
//
// Handshake: start is a level sampled on a rising edge while in IDLE; the
// first bit appears in the very next cycle. start while busy is dropped, not
// queued. done and err are single-cycle pulses; no acknowledgement is needed.
module seq_generator #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next output bit is picked by shifting the selected word right by the
  // selected position, which avoids an index wider than the vector needs.
  logic [WIDTH-1:0] sel_pat;
  logic [LEN_W-1:0] sel_idx;
  logic [WIDTH-1:0] shifted;
  logic             len_ok;
  logic             last_bit;

  assign len_ok   = (len != '0) && (len <= MAX_LEN);
  assign last_bit = (bit_idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    rep_left_d = rep_left_q;
    pat_d      = pat_q;
    len_d      = len_q;
    x_d        = IDLE_BIT;
    valid_d    = 1'b0;
    fs_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sel_pat    = pat_q;
    sel_idx    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_d      = pattern;
            len_d      = len;
            rep_left_d = reps;
            bit_idx_d  = '0;
            state_d    = S_SHIFT;
            valid_d    = 1'b1;
            fs_d       = 1'b1;
            busy_d     = 1'b1;
            sel_pat    = pattern;
            sel_idx    = len - LEN_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        // stop beats both the frame wrap and the move to DONE.
        if (stop) begin
          state_d = S_IDLE;
        end else if (last_bit) begin
          // rep_left of 0 marks a continuous job and is never decremented.
          if (rep_left_q == '0 || rep_left_q > REP_W'(1)) begin
            if (rep_left_q != '0) rep_left_d = rep_left_q - REP_W'(1);
            bit_idx_d = '0;
            valid_d   = 1'b1;
            fs_d      = 1'b1;
            busy_d    = 1'b1;
            sel_idx   = len_q - LEN_W'(1);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          bit_idx_d = bit_idx_q + LEN_W'(1);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          sel_idx   = len_q - bit_idx_q - LEN_W'(2);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    shifted = sel_pat >> sel_idx;
    if (valid_d) x_d = shifted[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      rep_left_q <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      x_q        <= IDLE_BIT;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      rep_left_q <= rep_left_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      x_q        <= x_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign x           = x_q;
  assign valid       = valid_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_generator.sv
// Testbench for seq_generator. Observed output vector per cycle:
// {busy, valid, x, frame_start, done, err}.
module tb_seq_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [7:0] reps;
  logic       x, valid, frame_start, busy, done, err;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];

  seq_generator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pattern     (pattern),
    .len         (len),
    .reps        (reps),
    .x           (x),
    .valid       (valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick(output logic [5:0] obs);
    @(posedge clk);
    @(negedge clk);
    obs = {busy, valid, x, frame_start, done, err};
  endtask

  task automatic drive_start(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
  endtask

  // Reference model: expected per-cycle outputs of a finite job, followed by
  // the DONE cycle and one IDLE cycle.
  task automatic push_job(input logic [7:0] p, input int l, input int r);
    for (int f = 0; f < r; f++)
      for (int i = 0; i < l; i++)
        exp_q.push_back({1'b1, 1'b1, p[l-1-i], (i == 0), 1'b0, 1'b0});
    exp_q.push_back(6'b10_0010);
    exp_q.push_back(6'b00_0000);
  endtask

  // scenarios
  task automatic test_reset();
    logic [5:0] obs;
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    pattern = '0; len = '0; reps = '0;
    #12;
    obs = {busy, valid, x, frame_start, done, err};
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 6'b0); end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    reset = 1'b1;
    tick(obs);
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL reset_idle got=%b exp=%b", obs, 6'b0); end
  endtask

  task automatic test_basic();
    logic [5:0] obs, e;
    int n = 0;
    push_job(8'b0000_0110, 4, 1);
    drive_start(8'b0000_0110, 4'd4, 8'd1);
    while (exp_q.size() > 0) begin
      tick(obs);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL basic cyc=%0d got=%b exp=%b", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_loopback();
    logic [5:0] obs, e;
    logic [3:0] hist = '0;
    int         pos_q[$];
    int         n = 0;
    int         bitn = 0;
    int         want;
    pos_q = '{4, 8, 12};
    push_job(8'b0000_0110, 4, 3);
    drive_start(8'b0000_0110, 4'd4, 8'd3);
    while (exp_q.size() > 0) begin
      tick(obs);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL loopback cyc=%0d got=%b exp=%b", n, obs, e); end
      n++;
      // 0110 detector fed from x, clocked only on valid bits
      if (obs[4]) begin
        bitn++;
        hist = {hist[2:0], obs[3]};
        if (hist == 4'b0110) begin
          want = (pos_q.size() > 0) ? pos_q.pop_front() : -1;
          checks++;
          if (bitn != want) begin failures++; $display("FAIL loopback_det got=%0d exp=%0d", bitn, want); end
        end
      end
    end
    checks++;
    if (pos_q.size() != 0) begin failures++; $display("FAIL loopback_det_count got=%0d exp=0 missing", pos_q.size()); end
  endtask

  task automatic test_continuous_stop();
    logic [5:0] obs, e;
    int n = 0;
    for (int k = 0; k < 10; k++)
      exp_q.push_back({1'b1, 1'b1, (k % 3 != 1), (k % 3 == 0), 1'b0, 1'b0});
    repeat (3) exp_q.push_back(6'b0);
    drive_start(8'b0000_0101, 4'd3, 8'd0);
    while (exp_q.size() > 0) begin
      tick(obs);
      start = 1'b0;
      stop  = (n == 9);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL cont_stop cyc=%0d got=%b exp=%b", n, obs, e); end
      n++;
    end
    stop = 1'b0;
  endtask

  task automatic test_bad_len();
    logic [5:0] obs;
    logic [3:0] bad[2];
    bad = '{4'd0, 4'd9};
    for (int i = 0; i < 2; i++) begin
      drive_start(8'hFF, bad[i], 8'd1);
      tick(obs);
      start = 1'b0;
      checks++;
      if (obs !== 6'b00_0001) begin failures++; $display("FAIL bad_len_err len=%0d got=%b exp=%b", bad[i], obs, 6'b00_0001); end
      tick(obs);
      checks++;
      if (obs !== 6'b0) begin failures++; $display("FAIL bad_len_after len=%0d got=%b exp=%b", bad[i], obs, 6'b0); end
    end
  endtask

  task automatic test_ignore_restart();
    logic [5:0] obs, e;
    int n = 0;
    push_job(8'b0000_0110, 3, 2);
    drive_start(8'b0000_0110, 4'd3, 8'd2);
    while (exp_q.size() > 0) begin
      tick(obs);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL ignore_restart cyc=%0d got=%b exp=%b", n, obs, e); end
      // re-pulse during SHIFT and in the DONE cycle with a different job
      if (n == 2 || obs[1]) drive_start(8'b1111_1001, 4'd5, 8'd4);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_len1_maxreps();
    logic [5:0] obs, e;
    int n = 0;
    push_job(8'b0000_0001, 1, 255);
    drive_start(8'b1111_1101, 4'd1, 8'd255);
    pattern = 8'b0000_0001;
    while (exp_q.size() > 0) begin
      tick(obs);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL len1_maxreps cyc=%0d got=%b exp=%b", n, obs, e); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs, e;
    logic [7:0] p;
    int         r;
    int n = 0;
    for (int j = 0; j < 2; j++) begin
      p = 8'($urandom_range(0, 255));
      r = $urandom_range(1, 3);
      push_job(p, (j == 0) ? 8 : 5, r);
      drive_start(p, (j == 0) ? 4'd8 : 4'd5, 8'(r));
      while (exp_q.size() > 0) begin
        tick(obs);
        start = 1'b0;
        // change inputs freely while busy
        pattern = ~p;
        len     = 4'd2;
        reps    = 8'd7;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL back_to_back job=%0d cyc=%0d got=%b exp=%b", j, n, obs, e); end
        n++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] obs, e;
    int n = 0;
    drive_start(8'b1011_0111, 4'd8, 8'd2);
    tick(obs);
    start = 1'b0;
    tick(obs);
    #2 reset = 1'b0;
    #1;
    obs = {busy, valid, x, frame_start, done, err};
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs, 6'b0); end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL async_reset_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    reset = 1'b1;
    push_job(8'b0000_0010, 2, 1);
    drive_start(8'b0000_0010, 4'd2, 8'd1);
    while (exp_q.size() > 0) begin
      tick(obs);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL after_reset cyc=%0d got=%b exp=%b", n, obs, e); end
      n++;
    end
  endtask

  // main sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_continuous_stop();
    test_bad_len();
    test_ignore_restart();
    test_len1_maxreps();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
